// File: rtl/alu_issue_unit.sv
// alu_issue_unit
// Consumer end of the ALU reservation-station interface. Each cycle one
// ready, not-in-flight RS entry is picked round-robin and pushed through a
// two-stage pipeline (S1 operand register, S2 result register). The result
// is presented toward the CDB together with its ROB tag, and a one-hot
// broadcast pulse frees the RS slot when the CDB accepts the result.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous pipeline kill (branch mispredict)
//   rs_ready   per-entry "operands resolved and valid"
//   rs_r1/r2   per-entry 32-bit operands, entry i at [i*32 +: 32]
//   rs_op      per-entry funct3 code, entry i at [i*3 +: 3]
//   rs_cmp     per-entry 1 = compare op, 0 = arithmetic op
//   rs_tag     per-entry ROB tag, entry i at [i*tag_width +: tag_width]
//   cdb_grant  CDB accepts the result presented this cycle
//   bcast_rdy  one-hot completion pulse toward the RS
//   res_valid  result presented on res_tag/res_data
//   res_tag    ROB tag of the presented result
//   res_data   presented result value
//   busy       S1 or S2 occupied
//
// Handshake: res_valid/cdb_grant form a valid/ready pair. A transfer
// happens in a cycle where both are high; while res_valid is high and
// cdb_grant is low, res_tag/res_data hold steady and res_valid stays high.
module alu_issue_unit #(
    parameter int size      = 8,
    parameter int tag_width = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [size-1:0]           rs_ready,
    input  logic [size*32-1:0]        rs_r1,
    input  logic [size*32-1:0]        rs_r2,
    input  logic [size*3-1:0]         rs_op,
    input  logic [size-1:0]           rs_cmp,
    input  logic [size*tag_width-1:0] rs_tag,
    input  logic                      cdb_grant,
    output logic [size-1:0]           bcast_rdy,
    output logic                      res_valid,
    output logic [tag_width-1:0]      res_tag,
    output logic [31:0]               res_data,
    output logic                      busy
);

    localparam int IW = (size > 1) ? $clog2(size) : 1;

    // Pipeline state
    logic                 r_s1_valid;
    logic [31:0]          r_s1_r1;
    logic [31:0]          r_s1_r2;
    logic [2:0]           r_s1_op;
    logic                 r_s1_cmp;
    logic [tag_width-1:0] r_s1_tag;
    logic [IW-1:0]        r_s1_idx;
    logic                 r_s2_valid;
    logic [31:0]          r_s2_data;
    logic [tag_width-1:0] r_s2_tag;
    logic [IW-1:0]        r_s2_idx;
    logic [size-1:0]      r_inflight;
    logic [IW-1:0]        r_rr_ptr;

    logic                 w_complete;
    logic                 w_s1_adv;
    logic                 w_issue;
    logic [size-1:0]      w_cand;
    logic                 w_found;
    logic [IW-1:0]        w_sel;
    logic [IW-1:0]        w_probe;
    logic [size-1:0]      w_inflight_nxt;
    logic [4:0]           w_shamt;
    logic [31:0]          w_alu;
    logic                 w_cond;
    logic [31:0]          w_result;

    // Flush suppresses completion, so no slot is freed by a killed result.
    assign w_complete = r_s2_valid & cdb_grant & ~flush;
    assign w_s1_adv   = r_s1_valid & (~r_s2_valid | w_complete);
    assign w_issue    = w_found & (~r_s1_valid | w_s1_adv) & ~flush;

    // A completing entry still has its inflight bit set, so it cannot be
    // reselected in the same cycle it broadcasts.
    assign w_cand = rs_ready & ~r_inflight;

    // Round-robin pick: scan from the farthest offset down so the nearest
    // candidate at or after r_rr_ptr wins. size is a power of two, so the
    // IW-bit sum wraps modulo size for free.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_probe = '0;
        for (int k = size - 1; k >= 0; k--) begin
            w_probe = r_rr_ptr + IW'(k);
            if (w_cand[w_probe]) begin
                w_found = 1'b1;
                w_sel   = w_probe;
            end
        end
    end

    // S1 -> S2 execute
    assign w_shamt = r_s1_r2[4:0];

    always_comb begin
        w_alu  = '0;
        w_cond = 1'b0;
        case (r_s1_op)
            3'b000: w_alu = r_s1_r1 + r_s1_r2;
            3'b001: w_alu = r_s1_r1 << w_shamt;
            3'b010: w_alu = 32'($signed(r_s1_r1) >>> w_shamt);
            3'b011: w_alu = r_s1_r1 - r_s1_r2;
            3'b100: w_alu = r_s1_r1 ^ r_s1_r2;
            3'b101: w_alu = r_s1_r1 >> w_shamt;
            3'b110: w_alu = r_s1_r1 | r_s1_r2;
            default: w_alu = r_s1_r1 & r_s1_r2;
        endcase
        case (r_s1_op)
            3'b000: w_cond = (r_s1_r1 == r_s1_r2);
            3'b001: w_cond = (r_s1_r1 != r_s1_r2);
            3'b100: w_cond = ($signed(r_s1_r1) <  $signed(r_s1_r2));
            3'b101: w_cond = ($signed(r_s1_r1) >= $signed(r_s1_r2));
            3'b110: w_cond = (r_s1_r1 <  r_s1_r2);
            3'b111: w_cond = (r_s1_r1 >= r_s1_r2);
            default: w_cond = 1'b0;
        endcase
        w_result = r_s1_cmp ? {31'b0, w_cond} : w_alu;
    end

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_complete) w_inflight_nxt[r_s2_idx] = 1'b0;
        if (w_issue)    w_inflight_nxt[w_sel]    = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_r1    <= '0;
            r_s1_r2    <= '0;
            r_s1_op    <= '0;
            r_s1_cmp   <= 1'b0;
            r_s1_tag   <= '0;
            r_s1_idx   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_tag   <= '0;
            r_s2_idx   <= '0;
            r_inflight <= '0;
            r_rr_ptr   <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_inflight <= '0;
        end else begin
            if (w_issue) begin
                r_s1_r1  <= rs_r1[w_sel*32 +: 32];
                r_s1_r2  <= rs_r2[w_sel*32 +: 32];
                r_s1_op  <= rs_op[w_sel*3 +: 3];
                r_s1_cmp <= rs_cmp[w_sel];
                r_s1_tag <= rs_tag[w_sel*tag_width +: tag_width];
                r_s1_idx <= w_sel;
                r_rr_ptr <= w_sel + IW'(1);
            end
            r_s1_valid <= w_issue | (r_s1_valid & ~w_s1_adv);
            // S2 payload only loads on advance, keeping it stable under stall.
            if (w_s1_adv) begin
                r_s2_data <= w_result;
                r_s2_tag  <= r_s1_tag;
                r_s2_idx  <= r_s1_idx;
            end
            r_s2_valid <= w_s1_adv | (r_s2_valid & ~w_complete);
            r_inflight <= w_inflight_nxt;
        end
    end

    always_comb begin
        bcast_rdy = '0;
        if (w_complete) bcast_rdy[r_s2_idx] = 1'b1;
    end

    assign res_valid = r_s2_valid & ~flush;
    assign res_tag   = r_s2_tag;
    assign res_data  = r_s2_data;
    assign busy      = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit
// Directed bench for alu_issue_unit (size=8, tag_width=4). Inputs change
// 1 time unit after a rising edge; outputs are checked 1 unit later, well
// away from the next edge.
module tb_alu_issue_unit;
    localparam int SIZE = 8;
    localparam int TW   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic [SIZE-1:0]   rs_ready = '0;
    logic [SIZE*32-1:0] rs_r1 = '0;
    logic [SIZE*32-1:0] rs_r2 = '0;
    logic [SIZE*3-1:0] rs_op = '0;
    logic [SIZE-1:0]   rs_cmp = '0;
    logic [SIZE*TW-1:0] rs_tag = '0;
    logic              cdb_grant = 1'b0;
    logic [SIZE-1:0]   bcast_rdy;
    logic              res_valid;
    logic [TW-1:0]     res_tag;
    logic [31:0]       res_data;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_tag_q[$];
    logic [31:0] exp_idx_q[$];

    alu_issue_unit #(.size(SIZE), .tag_width(TW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rs_ready(rs_ready), .rs_r1(rs_r1), .rs_r2(rs_r2),
        .rs_op(rs_op), .rs_cmp(rs_cmp), .rs_tag(rs_tag),
        .cdb_grant(cdb_grant), .bcast_rdy(bcast_rdy),
        .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
        .busy(busy)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rs();
        rs_ready = '0;
        rs_r1 = '0;
        rs_r2 = '0;
        rs_op = '0;
        rs_cmp = '0;
        rs_tag = '0;
    endtask

    task automatic set_entry(input int i, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic c, input logic [3:0] t);
        rs_r1[i*32 +: 32] = a;
        rs_r2[i*32 +: 32] = b;
        rs_op[i*3 +: 3]   = op;
        rs_cmp[i]         = c;
        rs_tag[i*TW +: TW] = t;
    endtask

    task automatic push_exp(input logic [31:0] t, input logic [31:0] d, input int idx);
        exp_tag_q.push_back(t);
        exp_q.push_back(d);
        exp_idx_q.push_back(32'(idx));
    endtask

    // Reset pulse that leaves the bench just after a rising edge.
    task automatic reset_dut();
        rst = 1'b0;
        flush = 1'b0;
        cdb_grant = 1'b0;
        clear_rs();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    // Streaming run with grant held high: n issues in cycles 0..n-1,
    // results in cycles 2..n+1, RS drops its ready bits at cycle n,
    // pipeline idle at cycle n+2.
    task automatic run_stream(input int n);
        logic [31:0] e_tag, e_data, e_idx;
        for (int c = 0; c <= n + 2; c++) begin
            if (c == n) rs_ready = '0;
            #1;
            if (c >= 2 && c <= n + 1) begin
                e_tag  = exp_tag_q.pop_front();
                e_data = exp_q.pop_front();
                e_idx  = exp_idx_q.pop_front();
                chk("stream_valid", 32'(res_valid), 32'd1);
                chk("stream_tag",   32'(res_tag), e_tag);
                chk("stream_data",  res_data, e_data);
                chk("stream_bcast", 32'(bcast_rdy), 32'(1) << e_idx);
            end
            if (c == n + 2) begin
                chk("stream_idle_busy",  32'(busy), 32'd0);
                chk("stream_idle_valid", 32'(res_valid), 32'd0);
            end
            tick();
        end
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_bcast", 32'(bcast_rdy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_tag",   32'(res_tag), 32'd0);
        chk("rst_data",  res_data, 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // single issue: entry 2, 5+7, tag 3
        set_entry(2, 32'd5, 32'd7, 3'b000, 1'b0, 4'd3);
        rs_ready = 8'h04;
        cdb_grant = 1'b1;
        #1;
        chk("single_c0_valid", 32'(res_valid), 32'd0);
        tick();
        chk("single_c1_busy",  32'(busy), 32'd1);
        chk("single_c1_valid", 32'(res_valid), 32'd0);
        chk("single_c1_bcast", 32'(bcast_rdy), 32'd0);
        tick();
        chk("single_c2_valid", 32'(res_valid), 32'd1);
        chk("single_c2_tag",   32'(res_tag), 32'd3);
        chk("single_c2_data",  res_data, 32'd12);
        chk("single_c2_bcast", 32'(bcast_rdy), 32'h04);
        tick();
        rs_ready = '0;
        #1;
        chk("single_c3_valid", 32'(res_valid), 32'd0);
        chk("single_c3_busy",  32'(busy), 32'd0);
        tick();

        // round robin: all ready, order 0..7 then 0 again
        reset_dut();
        for (int i = 0; i < SIZE; i++) set_entry(i, 32'(i), 32'd100, 3'b000, 1'b0, 4'(i));
        for (int k = 0; k < 9; k++) push_exp(32'(k % 8), 32'(k % 8 + 100), k % 8);
        rs_ready = 8'hFF;
        cdb_grant = 1'b1;
        run_stream(9);

        // back-pressure: entries 1 and 2, grant low 3 cycles
        reset_dut();
        set_entry(1, 32'd10, 32'd3, 3'b011, 1'b0, 4'd5);
        set_entry(2, 32'd6,  32'd3, 3'b100, 1'b0, 4'd6);
        set_entry(3, 32'd1,  32'd1, 3'b000, 1'b0, 4'd7);
        rs_ready = 8'h06;
        tick();
        tick();
        rs_ready = 8'h0E;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_stall_valid", 32'(res_valid), 32'd1);
            chk("bp_stall_tag",   32'(res_tag), 32'd5);
            chk("bp_stall_data",  res_data, 32'd7);
            chk("bp_stall_bcast", 32'(bcast_rdy), 32'd0);
            chk("bp_stall_busy",  32'(busy), 32'd1);
            tick();
        end
        cdb_grant = 1'b1;
        #1;
        chk("bp_g0_bcast", 32'(bcast_rdy), 32'h02);
        chk("bp_g0_tag",   32'(res_tag), 32'd5);
        tick();
        rs_ready = '0;
        #1;
        chk("bp_g1_bcast", 32'(bcast_rdy), 32'h04);
        chk("bp_g1_tag",   32'(res_tag), 32'd6);
        chk("bp_g1_data",  res_data, 32'd5);
        tick();
        chk("bp_g2_bcast", 32'(bcast_rdy), 32'h08);
        chk("bp_g2_tag",   32'(res_tag), 32'd7);
        chk("bp_g2_data",  res_data, 32'd2);
        tick();
        chk("bp_idle_busy", 32'(busy), 32'd0);

        // compare ops: r1=-1, r2=1
        reset_dut();
        set_entry(0, 32'hFFFF_FFFF, 32'd1, 3'b100, 1'b1, 4'd8);
        set_entry(1, 32'hFFFF_FFFF, 32'd1, 3'b110, 1'b1, 4'd9);
        set_entry(2, 32'hFFFF_FFFF, 32'd1, 3'b001, 1'b1, 4'd10);
        set_entry(3, 32'hFFFF_FFFF, 32'd1, 3'b000, 1'b1, 4'd11);
        set_entry(4, 32'hFFFF_FFFF, 32'd1, 3'b101, 1'b1, 4'd12);
        set_entry(5, 32'hFFFF_FFFF, 32'd1, 3'b111, 1'b1, 4'd13);
        set_entry(6, 32'hFFFF_FFFF, 32'd1, 3'b010, 1'b1, 4'd14);
        push_exp(8,  32'd1, 0);
        push_exp(9,  32'd0, 1);
        push_exp(10, 32'd1, 2);
        push_exp(11, 32'd0, 3);
        push_exp(12, 32'd0, 4);
        push_exp(13, 32'd1, 5);
        push_exp(14, 32'd0, 6);
        rs_ready = 8'h7F;
        cdb_grant = 1'b1;
        run_stream(7);

        // arithmetic edges
        reset_dut();
        set_entry(0, 32'hFFFF_FFFF, 32'd1,  3'b000, 1'b0, 4'd15);
        set_entry(1, 32'h8000_0000, 32'd31, 3'b010, 1'b0, 4'd14);
        set_entry(2, 32'd1,         32'd33, 3'b001, 1'b0, 4'd13);
        set_entry(3, 32'd0,         32'd1,  3'b011, 1'b0, 4'd12);
        set_entry(4, 32'h8000_0000, 32'd4,  3'b101, 1'b0, 4'd11);
        set_entry(5, 32'h0000_00F0, 32'h0F, 3'b110, 1'b0, 4'd10);
        set_entry(6, 32'h0000_00F0, 32'h3C, 3'b111, 1'b0, 4'd9);
        set_entry(7, 32'h0000_1234, 32'hFF, 3'b100, 1'b0, 4'd8);
        push_exp(15, 32'h0000_0000, 0);
        push_exp(14, 32'hFFFF_FFFF, 1);
        push_exp(13, 32'h0000_0002, 2);
        push_exp(12, 32'hFFFF_FFFF, 3);
        push_exp(11, 32'h0800_0000, 4);
        push_exp(10, 32'h0000_00FF, 5);
        push_exp(9,  32'h0000_0030, 6);
        push_exp(8,  32'h0000_12CB, 7);
        rs_ready = 8'hFF;
        cdb_grant = 1'b1;
        run_stream(8);

        // flush with two ops in S1/S2 and grant high
        reset_dut();
        set_entry(0, 32'd1, 32'd1, 3'b000, 1'b0, 4'd1);
        set_entry(1, 32'd2, 32'd2, 3'b000, 1'b0, 4'd2);
        set_entry(2, 32'd3, 32'd3, 3'b000, 1'b0, 4'd4);
        rs_ready = 8'h03;
        cdb_grant = 1'b1;
        tick();
        tick();
        rs_ready = 8'h07;
        flush = 1'b1;
        #1;
        chk("flush_bcast", 32'(bcast_rdy), 32'd0);
        chk("flush_valid", 32'(res_valid), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_next_busy",  32'(busy), 32'd0);
        chk("flush_next_valid", 32'(res_valid), 32'd0);
        tick();
        tick();
        #1;
        chk("reissue0_tag",   32'(res_tag), 32'd4);
        chk("reissue0_data",  res_data, 32'd6);
        chk("reissue0_bcast", 32'(bcast_rdy), 32'h04);
        tick();
        rs_ready = '0;
        #1;
        chk("reissue1_tag",   32'(res_tag), 32'd1);
        chk("reissue1_data",  res_data, 32'd2);
        chk("reissue1_bcast", 32'(bcast_rdy), 32'h01);
        tick();
        chk("reissue2_tag",   32'(res_tag), 32'd2);
        chk("reissue2_data",  res_data, 32'd4);
        chk("reissue2_bcast", 32'(bcast_rdy), 32'h02);
        tick();
        chk("reissue_idle_busy", 32'(busy), 32'd0);

        // reset mid-operation
        clear_rs();
        set_entry(5, 32'd1, 32'd2, 3'b000, 1'b0, 4'd9);
        rs_ready = 8'h20;
        cdb_grant = 1'b0;
        tick();
        tick();
        chk("midrst_pre_valid", 32'(res_valid), 32'd1);
        chk("midrst_pre_data",  res_data, 32'd3);
        #2;
        rst = 1'b0;
        cdb_grant = 1'b1;
        #1;
        chk("midrst_valid", 32'(res_valid), 32'd0);
        chk("midrst_bcast", 32'(bcast_rdy), 32'd0);
        chk("midrst_busy",  32'(busy), 32'd0);
        chk("midrst_data",  res_data, 32'd0);
        chk("midrst_tag",   32'(res_tag), 32'd0);
        rs_ready = '0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("midrst_after_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
